// File: rtl/key_draw_scheduler_if.sv
// Frame-buffer write bus between the scheduler and vga_adapter.
// Signals: x (8), y (7), colour (3), plot strobe.
interface key_draw_scheduler_if;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;

  modport master (
    output x, y, colour, plot
  );
  modport slave (
    input x, y, colour, plot
  );
endinterface

// File: rtl/key_draw_scheduler.sv
// Owns the frame-buffer bus: full keyboard paint, then per-key repaints.
// Ports: clock, reset (async low), key_state, fb bus, busy, drawn_keys.
module key_draw_scheduler #(
  parameter logic [2:0] FILL_COLOUR   = 3'b111,
  parameter logic [2:0] PRESS_COLOUR  = 3'b100,
  parameter logic [2:0] BORDER_COLOUR = 3'b000
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [3:0]                  key_state,
  key_draw_scheduler_if.master        fb,
  output logic                        busy,
  output logic [3:0]                  drawn_keys
);

  typedef enum logic [1:0] {
    S_INIT,
    S_IDLE,
    S_KEY
  } state_t;

  state_t      r_state;
  state_t      w_state_nx;
  logic [7:0]  r_cx;
  logic [6:0]  r_cy;
  logic [1:0]  r_rr;
  logic [1:0]  r_k;
  logic        r_target;
  logic [3:0]  r_drawn;
  logic [7:0]  r_x;
  logic [6:0]  r_y;
  logic [2:0]  r_colour;
  logic        r_plot;

  logic [3:0]  w_pending;
  logic        w_grant;
  logic        w_found;
  logic [1:0]  w_gk;
  logic [1:0]  w_idx;
  logic [7:0]  w_base;
  logic [7:0]  w_gbase;
  logic        w_row_end;
  logic        w_last;
  logic        w_border;
  logic [2:0]  w_pix_col;

  assign w_pending = key_state ^ r_drawn;

  // 40*k built as 32*k + 8*k
  assign w_base  = {1'b0, r_k, 5'b0}
                 + {3'b0, r_k, 3'b0};
  assign w_gbase = {1'b0, w_gk, 5'b0}
                 + {3'b0, w_gk, 3'b0};

  assign w_border = (r_cx == 8'd39)
                 || (r_cx == 8'd79)
                 || (r_cx == 8'd119)
                 || (r_cx == 8'd159);

  always_comb begin
    w_row_end = 1'b0;
    w_pix_col = FILL_COLOUR;
    if (r_state == S_KEY) begin
      w_row_end = (r_cx == w_base + 8'd38);
      w_pix_col = r_target ? PRESS_COLOUR
                           : FILL_COLOUR;
    end else begin
      w_row_end = (r_cx == 8'd159);
      w_pix_col = w_border ? BORDER_COLOUR
                           : FILL_COLOUR;
    end
  end

  assign w_last = w_row_end && (r_cy == 7'd119);

  // round-robin search starting at r_rr
  always_comb begin
    w_found = 1'b0;
    w_gk    = r_rr;
    w_idx   = r_rr;
    for (int i = 0; i < 4; i++) begin
      w_idx = r_rr + 2'(i);
      if (!w_found && w_pending[w_idx]) begin
        w_found = 1'b1;
        w_gk    = w_idx;
      end
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_grant    = 1'b0;
    unique case (r_state)
      S_INIT: begin
        if (w_last) w_state_nx = S_IDLE;
      end
      S_IDLE: begin
        if (w_found) begin
          w_grant    = 1'b1;
          w_state_nx = S_KEY;
        end
      end
      S_KEY: begin
        if (w_last) w_state_nx = S_IDLE;
      end
      default: w_state_nx = S_INIT;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state  <= S_INIT;
      r_cx     <= '0;
      r_cy     <= '0;
      r_rr     <= '0;
      r_k      <= '0;
      r_target <= 1'b0;
      r_drawn  <= '0;
      r_x      <= '0;
      r_y      <= '0;
      r_colour <= '0;
      r_plot   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_plot  <= 1'b0;
      if (r_state == S_IDLE) begin
        if (w_grant) begin
          r_k      <= w_gk;
          r_target <= key_state[w_gk];
          r_cx     <= w_gbase;
          r_cy     <= '0;
          r_rr     <= w_gk + 2'd1;
        end
      end else begin
        r_x      <= r_cx;
        r_y      <= r_cy;
        r_colour <= w_pix_col;
        r_plot   <= 1'b1;
        if (w_row_end) begin
          r_cx <= (r_state == S_KEY) ? w_base
                                     : 8'd0;
          r_cy <= (r_cy == 7'd119) ? 7'd0
                                   : r_cy + 7'd1;
        end else begin
          r_cx <= r_cx + 8'd1;
        end
        if (r_state == S_KEY && w_last)
          r_drawn[r_k] <= r_target;
      end
    end
  end

  assign fb.x       = r_x;
  assign fb.y       = r_y;
  assign fb.colour  = r_colour;
  assign fb.plot    = r_plot;
  assign busy       = (r_state != S_IDLE);
  assign drawn_keys = r_drawn;

endmodule

// File: tb/tb_key_draw_scheduler.sv
// Bench for key_draw_scheduler: init paint, repaints, reset.
// Drives key_state/reset, watches fb bus, busy, drawn_keys.
module tb_key_draw_scheduler;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] key_state = 4'b0000;
  logic       busy;
  logic [3:0] drawn_keys;

  key_draw_scheduler_if fb ();

  key_draw_scheduler dut (
    .clock      (clock),
    .reset      (reset),
    .key_state  (key_state),
    .fb         (fb),
    .busy       (busy),
    .drawn_keys (drawn_keys)
  );

  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic [3:0] ks;
    int         key;
    logic [2:0] col;
    logic [3:0] drawn;
    int         exp_w;
    int         tog_at;
    logic [3:0] tog_ks;
  } vec_t;

  vec_t tbl [5];

  task automatic check(input bit ok,
                       input string name,
                       input string info);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: %s", name, info);
  endtask

  task automatic paint(input string name,
                       input bit init,
                       input int xlo,
                       input int xhi,
                       input logic [2:0] col,
                       input int exp_w,
                       input int tog_at,
                       input logic [3:0] tog_val,
                       input bit pulse,
                       input logic [3:0] restore);
    int w;
    int errs;
    int ex;
    int ey;
    int n;
    logic [2:0] ec;
    logic eb;
    string bad;
    bad = "";
    n = (xhi - xlo + 1) * 120;
    w = 0;
    @(negedge clock);
    while (!fb.plot && w < 64) begin
      w++;
      @(negedge clock);
    end
    check(w == exp_w, {name, " start"},
          $sformatf("waited %0d cycles, want %0d",
                    w, exp_w));
    errs = 0;
    ex = xlo;
    ey = 0;
    for (int i = 0; i < n; i++) begin
      ec = (init && (ex % 40 == 39)) ? 3'b000 : col;
      eb = (i != n - 1);
      if (fb.plot !== 1'b1 || fb.x !== ex[7:0] ||
          fb.y !== ey[6:0] || fb.colour !== ec ||
          busy !== eb) begin
        if (errs == 0)
          bad = $sformatf(
            "pix %0d got x=%0d y=%0d c=%0d p=%0b b=%0b want x=%0d y=%0d c=%0d p=1 b=%0b",
            i, fb.x, fb.y, fb.colour, fb.plot, busy,
            ex, ey, ec, eb);
        errs++;
      end
      if (i == tog_at) key_state = tog_val;
      if (pulse && i == tog_at + 1) key_state = restore;
      ex++;
      if (ex > xhi) begin
        ex = xlo;
        ey++;
      end
      @(negedge clock);
    end
    check(errs == 0, {name, " pixels"},
          $sformatf("%0d bad, first %s", errs, bad));
    check(fb.plot == 1'b0, {name, " end"},
          $sformatf("plot=%0b after last pixel, want 0",
                    fb.plot));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit hit, want finish");
    $fatal(1);
  end

  initial begin
    int w;
    int hi;
    tbl[0] = '{4'b1001, 0, 3'b100, 4'b0001, 1, -1, 4'b0};
    tbl[1] = '{4'b1001, 3, 3'b100, 4'b1001, 0, -1, 4'b0};
    tbl[2] = '{4'b1101, 2, 3'b100, 4'b1101, 1, -1, 4'b0};
    tbl[3] = '{4'b1111, 1, 3'b100, 4'b1111, 1, 1000,
               4'b1101};
    tbl[4] = '{4'b1101, 1, 3'b111, 4'b1101, 0, -1, 4'b0};

    #23;
    check(fb.plot == 0, "rst plot",
          $sformatf("got %0b want 0", fb.plot));
    check(fb.x == 0, "rst x",
          $sformatf("got %0d want 0", fb.x));
    check(fb.y == 0, "rst y",
          $sformatf("got %0d want 0", fb.y));
    check(fb.colour == 0, "rst colour",
          $sformatf("got %0d want 0", fb.colour));
    check(drawn_keys == 0, "rst drawn",
          $sformatf("got %b want 0000", drawn_keys));
    check(busy == 1, "rst busy",
          $sformatf("got %0b want 1", busy));

    @(negedge clock);
    reset = 1'b1;
    paint("init", 1, 0, 159, 3'b111, 0,
          -1, 4'b0, 0, 4'b0);
    check(drawn_keys == 4'b0000, "init drawn",
          $sformatf("got %b want 0000", drawn_keys));
    check(busy == 1'b0, "init busy",
          $sformatf("got %0b want 0", busy));

    for (int i = 0; i < 5; i++) begin
      key_state = tbl[i].ks;
      paint($sformatf("vec%0d", i), 0,
            40 * tbl[i].key, 40 * tbl[i].key + 38,
            tbl[i].col, tbl[i].exp_w,
            tbl[i].tog_at, tbl[i].tog_ks, 0, 4'b0);
      check(drawn_keys == tbl[i].drawn,
            $sformatf("vec%0d drawn", i),
            $sformatf("got %b want %b",
                      drawn_keys, tbl[i].drawn));
    end

    key_state = 4'b1001;
    w = 0;
    @(negedge clock);
    while (!fb.plot && w < 64) begin
      w++;
      @(negedge clock);
    end
    check(w == 1 && fb.x == 80 && fb.colour == 3'b111,
          "key2 start",
          $sformatf("wait=%0d x=%0d c=%0d want 1 80 7",
                    w, fb.x, fb.colour));
    repeat (2000) @(negedge clock);
    #2;
    reset = 1'b0;
    #1;
    check(fb.plot == 0 && fb.x == 0 && fb.y == 0 &&
          fb.colour == 0, "midrst bus",
          $sformatf("p=%0b x=%0d y=%0d c=%0d want 0s",
                    fb.plot, fb.x, fb.y, fb.colour));
    check(drawn_keys == 0, "midrst drawn",
          $sformatf("got %b want 0000", drawn_keys));
    check(busy == 1, "midrst busy",
          $sformatf("got %0b want 1", busy));
    key_state = 4'b0000;
    @(negedge clock);
    reset = 1'b1;
    paint("reinit", 1, 0, 159, 3'b111, 0,
          3000, 4'b1000, 1, 4'b0000);
    check(drawn_keys == 4'b0000, "reinit drawn",
          $sformatf("got %b want 0000", drawn_keys));
    hi = 0;
    repeat (20) begin
      @(negedge clock);
      if (fb.plot || busy) hi++;
    end
    check(hi == 0, "pulse ignored",
          $sformatf("%0d active cycles, want 0", hi));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
